// File: rtl/spi_master.sv
// Single-byte SPI master: one 8-bit full-duplex MSB-first frame per request.
// Active-high one-hot slave select; SCK runs at Clk_i / (2*CLKDIV).
module spi_master #(
  parameter int unsigned NSLAVES = 4,
  parameter int unsigned SELW    = (NSLAVES > 1) ? $clog2(NSLAVES) : 1,
  parameter int unsigned CLKDIV  = 4
) (
  input  logic               Clk_i,
  input  logic               Rst_ni,
  input  logic               start_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic [7:0]         tx_data_i,
  output logic [7:0]         rx_data_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               sck_o,
  output logic               mosi_o,
  input  logic               miso_i,
  output logic [NSLAVES-1:0] ss_o
);

  localparam int unsigned CNTW  = $clog2(CLKDIV);
  localparam int unsigned BITW  = 4;
  localparam int unsigned BYTEW = 8;

  if (CLKDIV < 4) begin : g_clkdiv_chk
    $error("spi_master: CLKDIV must be >= 4");
  end
  if (NSLAVES < 1) begin : g_nslaves_chk
    $error("spi_master: NSLAVES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [BITW-1:0]    bit_q, bit_d;
  logic [BYTEW-1:0]   tx_q, tx_d;
  logic [BYTEW-1:0]   rx_sh_q, rx_sh_d;
  logic [SELW-1:0]    sel_q, sel_d;

  logic [BYTEW-1:0]   rx_data_q, rx_data_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [NSLAVES-1:0] ss_q, ss_d;

  logic cnt_last;
  logic sel_ok;
  logic in_frame;

  // Widened compare so a power-of-two NSLAVES does not fold to a constant.
  assign sel_ok   = ({1'b0, sel_i} < (SELW+1)'(NSLAVES));
  assign cnt_last = (cnt_q == CNTW'(CLKDIV - 1));
  assign in_frame = (state_q == SETUP) || (state_q == HIGH) ||
                    (state_q == LOW)   || (state_q == HOLD);

  // Next-state logic; outputs are a registered decode of the current state,
  // so every pin change lands one cycle after the state transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_last ? '0 : cnt_q + CNTW'(1);
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    sel_d     = sel_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    busy_d    = (state_q != IDLE);
    sck_d     = (state_q == HIGH);
    ss_d      = in_frame ? (NSLAVES'(1) << sel_q) : '0;
    mosi_d    = in_frame ? tx_q[BYTEW-1] : 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i && sel_ok) begin
          tx_d    = tx_data_i;
          sel_d   = sel_i;
          bit_d   = '0;
          rx_sh_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_last) state_d = HIGH;
      end
      HIGH: begin
        // First HIGH cycle is the edge on which sck_o rises.
        if (cnt_q == '0) begin
          rx_sh_d = {rx_sh_q[BYTEW-2:0], miso_i};
          bit_d   = bit_q + BITW'(1);
        end
        if (cnt_last) begin
          if (bit_q < BITW'(BYTEW)) begin
            tx_d    = {tx_q[BYTEW-2:0], 1'b0};
            state_d = LOW;
          end else begin
            state_d = HOLD;
          end
        end
      end
      LOW: begin
        if (cnt_last) state_d = HIGH;
      end
      HOLD: begin
        if (cnt_last) state_d = GAP;
      end
      GAP: begin
        if (cnt_q == '0) begin
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
        if (cnt_last) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      sel_q     <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      sel_q     <= sel_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
    end
  end

  assign rx_data_o = rx_data_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign ss_o      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table of full frames plus
// directed back-to-back, mid-frame reset, out-of-range select and CLKDIV=6 cases.
module tb_spi_master;

  localparam int C4 = 4;
  localparam int C6 = 6;

  logic       clk;
  logic       rst_n;

  // CLKDIV=4, NSLAVES=4 instance
  logic       start;
  logic [1:0] sel;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       done, busy, sck, mosi, miso;
  logic [3:0] ss;

  // CLKDIV=6, NSLAVES=3 instance
  logic       start6;
  logic [1:0] sel6;
  logic [7:0] tx6;
  logic [7:0] rx6;
  logic       done6, busy6, sck6, mosi6, miso6;
  logic [2:0] ss6;

  logic       loopback;
  logic [7:0] slv_preload;
  logic [7:0] slv_sh;
  logic [2:0] sck_sync;
  logic       slv_miso;

  int checks;
  int failures;

  spi_master #(.NSLAVES(4), .CLKDIV(C4)) dut (
    .Clk_i(clk), .Rst_ni(rst_n), .start_i(start), .sel_i(sel),
    .tx_data_i(tx_data), .rx_data_o(rx_data), .done_o(done), .busy_o(busy),
    .sck_o(sck), .mosi_o(mosi), .miso_i(miso), .ss_o(ss)
  );

  spi_master #(.NSLAVES(3), .CLKDIV(C6)) dut6 (
    .Clk_i(clk), .Rst_ni(rst_n), .start_i(start6), .sel_i(sel6),
    .tx_data_i(tx6), .rx_data_o(rx6), .done_o(done6), .busy_o(busy6),
    .sck_o(sck6), .mosi_o(mosi6), .miso_i(miso6), .ss_o(ss6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave on ss[1]: synchronizes SCK, shifts on the detected rise.
  initial begin
    sck_sync = '0;
    slv_sh   = '0;
  end
  always @(posedge clk) begin
    sck_sync <= {sck_sync[1:0], sck};
    if (!ss[1])                         slv_sh <= slv_preload;
    else if (sck_sync[1] && !sck_sync[2]) slv_sh <= {slv_sh[6:0], mosi};
  end
  assign slv_miso = slv_sh[7];
  assign miso     = loopback ? mosi : slv_miso;
  assign miso6    = mosi6;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] sel;
    logic       lb;
    logic [7:0] preload;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete frame on the CLKDIV=4 instance, cycle-accurate against the timing table.
  task automatic run_frame4(input vec_t v, input string tag);
    int rises, bad_rise, ss_bad, busy_bad, done_cnt, done_cyc, busy_fall, mosi_bad;
    logic prev_sck, prev_mosi;
    logic [7:0] got_rx, got_slv;
    logic [3:0] exp_ss;
    rises = 0; bad_rise = 0; ss_bad = 0; busy_bad = 0; done_cnt = 0;
    done_cyc = -1; busy_fall = -1; mosi_bad = 0; got_rx = '0; got_slv = '0;
    loopback    = v.lb;
    slv_preload = v.preload;
    tx_data     = v.tx;
    sel         = v.sel;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    tx_data = ~v.tx;
    sel     = v.sel + 2'd1;
    prev_sck  = sck;
    prev_mosi = mosi;
    for (int n = 1; n <= 18*C4 + 1; n++) begin
      tick();
      exp_ss = (n <= 17*C4) ? (4'b0001 << v.sel) : 4'b0000;
      if (ss !== exp_ss) ss_bad++;
      if (busy !== (n <= 18*C4)) busy_bad++;
      if (sck && !prev_sck) begin
        rises++;
        if (((n - 1) % (2*C4)) != C4 || ss == '0) bad_rise++;
      end
      if (sck && prev_sck && (mosi !== prev_mosi)) mosi_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = n;
        got_rx   = rx_data;
        got_slv  = slv_sh;
      end
      if (!busy && busy_fall < 0) busy_fall = n;
      prev_sck  = sck;
      prev_mosi = mosi;
    end
    check($sformatf("%s ss_window", tag), 32'(ss_bad), 32'd0);
    check($sformatf("%s busy_window", tag), 32'(busy_bad), 32'd0);
    check($sformatf("%s sck_rises", tag), 32'(rises), 32'd8);
    check($sformatf("%s sck_rise_timing", tag), 32'(bad_rise), 32'd0);
    check($sformatf("%s mosi_stable_high", tag), 32'(mosi_bad), 32'd0);
    check($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(17*C4 + 1));
    check($sformatf("%s busy_fall", tag), 32'(busy_fall), 32'(18*C4 + 1));
    check($sformatf("%s rx_data", tag), 32'(got_rx), 32'(v.exp_rx));
    if (!v.lb) check($sformatf("%s slave_rcvd", tag), 32'(got_slv), 32'(v.exp_slv));
  endtask

  initial begin
    vec_t vecs[7];
    vec_t vr;
    int   last_done, nd, interval_bad, rx_bad, sck_idle_bad, bound;
    int   oor_bad, last_edge, hp_bad, hp_cnt, mosi6_bad, ss6_bad, done6_cyc, busy6_fall;
    logic [7:0] exp_tx, got6;
    logic prev6;
    logic [2:0] exp_ss6;

    checks = 0; failures = 0;
    vecs[0] = '{tx: 8'hA5, sel: 2'd2, lb: 1'b1, preload: 8'h00, exp_rx: 8'hA5, exp_slv: 8'h00};
    vecs[1] = '{tx: 8'hC3, sel: 2'd1, lb: 1'b0, preload: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'hC3};
    vecs[2] = '{tx: 8'h00, sel: 2'd1, lb: 1'b0, preload: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'h00};
    vecs[3] = '{tx: 8'hFF, sel: 2'd1, lb: 1'b0, preload: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'hFF};
    vecs[4] = '{tx: 8'h81, sel: 2'd1, lb: 1'b0, preload: 8'h3C, exp_rx: 8'h3C, exp_slv: 8'h81};
    vecs[5] = '{tx: 8'h5A, sel: 2'd0, lb: 1'b1, preload: 8'h00, exp_rx: 8'h5A, exp_slv: 8'h00};
    vecs[6] = '{tx: 8'h01, sel: 2'd3, lb: 1'b1, preload: 8'h00, exp_rx: 8'h01, exp_slv: 8'h00};

    rst_n = 1'b0; start = 1'b0; sel = '0; tx_data = '0; loopback = 1'b1; slv_preload = '0;
    start6 = 1'b0; sel6 = '0; tx6 = '0;
    repeat (3) tick();
    check("reset_state dut4", 32'({rx_data, done, busy, sck, mosi, ss}), 32'd0);
    check("reset_state dut6", 32'({rx6, done6, busy6, sck6, mosi6, ss6}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_frame4(vecs[i], $sformatf("vec%0d", i));

    // start_i held high: frames back-to-back at every IDLE cycle
    loopback = 1'b1; sel = 2'd0; exp_tx = 8'h10; tx_data = exp_tx; start = 1'b1;
    last_done = -1; nd = 0; interval_bad = 0; rx_bad = 0; sck_idle_bad = 0;
    for (int n = 0; n < 250; n++) begin
      tick();
      if (sck && ss == '0) sck_idle_bad++;
      if (done) begin
        if (rx_data !== exp_tx) rx_bad++;
        if (last_done >= 0 && (n - last_done) != 18*C4 + 1) interval_bad++;
        last_done = n;
        nd++;
        exp_tx  = exp_tx + 8'd1;
        tx_data = exp_tx;
      end
    end
    start = 1'b0;
    check("b2b done_count", 32'(nd), 32'd3);
    check("b2b frame_interval", 32'(interval_bad), 32'd0);
    check("b2b rx_data", 32'(rx_bad), 32'd0);
    check("b2b sck_outside_ss", 32'(sck_idle_bad), 32'd0);
    bound = 0;
    while (busy && bound < 200) begin
      tick();
      bound++;
    end
    check("b2b drain_idle", 32'(busy), 32'd0);
    tick();

    // Reset pulse at cycle 30 of a frame
    loopback = 1'b1; sel = 2'd3; tx_data = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("midframe busy", 32'({busy, ss}), 32'({1'b1, 4'b1000}));
    rst_n = 1'b0;
    #1;
    check("midframe async_reset", 32'({rx_data, done, busy, sck, mosi, ss}), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vr = '{tx: 8'h96, sel: 2'd3, lb: 1'b1, preload: 8'h00, exp_rx: 8'h96, exp_slv: 8'h00};
    run_frame4(vr, "post_reset");

    // Out-of-range select on the NSLAVES=3 instance
    oor_bad = 0; sel6 = 2'd3; tx6 = 8'hEE; start6 = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (busy6 || ss6 != '0 || sck6) oor_bad++;
    end
    start6 = 1'b0;
    check("oor_sel ignored", 32'(oor_bad), 32'd0);

    // CLKDIV=6 frame with a conflicting re-pulse mid-frame
    sel6 = 2'd2; tx6 = 8'hB4; start6 = 1'b1;
    tick();
    start6 = 1'b0; sel6 = 2'd0; tx6 = 8'h11;
    last_edge = -1; hp_bad = 0; hp_cnt = 0; mosi6_bad = 0; ss6_bad = 0;
    done6_cyc = -1; busy6_fall = -1; got6 = '0; prev6 = sck6;
    for (int n = 1; n <= 18*C6 + 1; n++) begin
      tick();
      if (n == 40) start6 = 1'b1;
      if (n == 42) start6 = 1'b0;
      exp_ss6 = (n <= 17*C6) ? 3'b100 : 3'b000;
      if (ss6 !== exp_ss6) ss6_bad++;
      if (sck6 !== prev6) begin
        if (last_edge >= 0 && (n - last_edge) != C6) hp_bad++;
        last_edge = n;
        hp_cnt++;
      end
      prev6 = sck6;
      if (done6) begin
        done6_cyc = n;
        got6      = rx6;
      end
      if (!busy6 && busy6_fall < 0) busy6_fall = n;
    end
    check("div6 half_period", 32'(hp_bad), 32'd0);
    check("div6 sck_transitions", 32'(hp_cnt), 32'd16);
    check("div6 ss_window", 32'(ss6_bad), 32'd0);
    check("div6 done_cycle", 32'(done6_cyc), 32'(17*C6 + 1));
    check("div6 rx_data", 32'(got6), 32'h0000_00B4);
    check("div6 busy_fall", 32'(busy6_fall), 32'(18*C6 + 1));
    for (int n = 0; n < 10; n++) begin
      tick();
      if (busy6) mosi6_bad++;
    end
    check("div6 restart_not_queued", 32'(mosi6_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Independent watcher: MOSI on the CLKDIV=6 instance never moves while SCK is high.
  int   mosi6_hi_bad;
  logic mosi6_prev, sck6_prev;
  initial begin
    mosi6_hi_bad = 0;
    mosi6_prev   = 1'b0;
    sck6_prev    = 1'b0;
  end
  always @(negedge clk) begin
    if (sck6 && sck6_prev && (mosi6 !== mosi6_prev)) begin
      mosi6_hi_bad <= mosi6_hi_bad + 1;
      failures++;
      checks++;
      $display("FAIL div6 mosi_changed_while_sck_high: got mosi=%0b previous=%0b", mosi6, mosi6_prev);
    end
    mosi6_prev <= mosi6;
    sck6_prev  <= sck6;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI master that runs one 8-bit full-duplex frame per request: it selects one of NSLAVES slaves, shifts a byte out on MOSI MSB-first and captures a byte from MISO. It is the initiating end of the design's SPI bus and is paired with the existing `slave` block. Slave select is active-high. The slave samples MOSI and advances MISO after it detects a synchronized SCK rising edge. All timing is derived from the system clock; SCK runs at Clk_i / (2·CLKDIV).

## Interface
- NSLAVES, 4, number of slave-select lines (≥1)
- SELW, $clog2(NSLAVES) (min 1), width of sel_i
- CLKDIV, 4, Clk_i cycles per SCK half-period; must be ≥4 (elaboration error otherwise)
- Clk_i  input  1  system clock, all logic on rising edge
- Rst_ni  input  1  asynchronous, active-low reset
- start_i  input  1  request a frame; sampled only in IDLE
- sel_i  input  SELW  slave index for the request
- tx_data_i  input  8  byte to send, captured at acceptance
- rx_data_o  output  8  last received byte, updated at frame end
- done_o  output  1  one-cycle pulse, rx_data_o valid from that cycle
- busy_o  output  1  frame in progress, including the trailing gap
- sck_o  output  1  SPI clock, idles low
- mosi_o  output  1  serial data out
- miso_i  input  1  serial data in, driven by the selected slave, same clock domain
- ss_o  output  NSLAVES  one-hot slave select, active-high

## Operation
- Reset values: rx_data_o=0x00, done_o=0, busy_o=0, sck_o=0, mosi_o=0, ss_o=0. FSM enters IDLE.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. One half-period counter counts 0..CLKDIV-1. One bit counter counts 0..8.
- IDLE: if start_i=1 and sel_i<NSLAVES:
  - latch tx_data_i into the shift register and latch sel_i;
  - go to SETUP.
- IDLE: start_i with sel_i≥NSLAVES is ignored. Nothing changes.
- SETUP (CLKDIV cycles): ss_o[sel]=1, sck_o=0, mosi_o=tx[7].
- Each edge that leaves SETUP or LOW for HIGH does three things:
  - sets sck_o=1;
  - shifts miso_i into the rx shift register LSB (rx <= {rx[6:0], miso_i});
  - increments the bit counter.
- HIGH (CLKDIV cycles), then:
  - bit counter <8: go to LOW, mosi_o=next tx bit (MSB-first);
  - bit counter =8: go to HOLD.
- LOW (CLKDIV cycles): sck_o=0, mosi_o stable.
- HOLD (CLKDIV cycles): sck_o=0, ss_o still asserted.
- HOLD exit: ss_o=0, mosi_o=0, rx_data_o<=rx shift register, done_o=1 for one cycle, go to GAP.
- GAP (CLKDIV cycles): ss_o=0, busy_o=1. Then go to IDLE with busy_o=0.
- busy_o is 1 in every state except IDLE.
- start_i while busy_o=1 is ignored. It is not queued.
- Changes to tx_data_i or sel_i after acceptance have no effect on the frame.
- Reset asserted mid-frame: all outputs go immediately to their reset values and the partial byte is discarded.
- Exactly 8 SCK rising edges per frame, none outside ss_o assertion.

## Timing
- Acceptance edge = cycle 0.
- ss_o[sel] and busy_o go high at cycle 1.
- First SCK rise at cycle CLKDIV+1. SCK rise k (k=1..8) at cycle (2k−1)·CLKDIV+1.
- miso_i is sampled on each SCK-rise edge. The slave updates MISO within 3 cycles of a rise, which is why CLKDIV≥4 is required.
- mosi_o changes only on SCK falling edges and at frame start. It is stable for ≥CLKDIV cycles before each rise.
- ss_o stays high for cycles 1..17·CLKDIV.
- done_o=1 at cycle 17·CLKDIV+1.
- busy_o falls at cycle 18·CLKDIV+1. The earliest next acceptance is that cycle.
- CLKDIV=4: ss high for cycles 1..68, rises at 5,13,…,61, done at 69, busy low at 73.

## Test plan
- Loopback: CLKDIV=4, miso_i tied to mosi_o, start with tx=0xA5, sel=2 -> ss_o=4'b0100 for cycles 1..68, 8 SCK rises at 5,13,…,61, done_o pulse at 69 with rx_data_o=0xA5, busy_o low at 73.
- Against a `slave` instance (ID=1) preloaded with 0x3C: master sends 0xC3 with sel=1 -> master rx_data_o=0x3C and slave Rcvd=0xC3. Repeat for 0x00, 0xFF and 0x81.
- start_i held high continuously with sel=0 and tx incrementing -> frames start exactly at every IDLE cycle, one done_o per frame, no SCK activity while ss_o=0.
- Rst_ni pulsed low at cycle 30 of a frame -> all outputs at reset values within the same cycle. A new frame after release completes correctly with no leftover bits.
- sel_i=NSLAVES (out of range) with start_i=1 -> busy_o stays 0, ss_o=0, sck_o=0.
- CLKDIV=6, start_i re-pulsed mid-frame with a different tx and sel -> ignored. Half-periods measure exactly 6 cycles, and mosi_o never changes while sck_o=1.
